// File: rtl/serial_circular_shifter_pkg.sv
// Shared types for the serial circular shifter: FSM state encoding and
// rotate-direction constants.
package serial_rot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/serial_circular_shifter_rot1_step.sv
// Combinational rotate-by-one-position. Left moves bits toward the MSB with
// the MSB wrapping into bit 0; right moves bits toward the LSB with bit 0
// wrapping into the MSB.
module rot1_step
  import serial_rot_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] data,
  input  logic         dir,
  output logic [N-1:0] rot_data
);

  // Each output bit picks its left or right neighbour, modulo N.
  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign rot_data[gi] = (dir == DIR_LEFT) ? data[(gi + N - 1) % N]
                                            : data[(gi + 1) % N];
  end

endmodule

// File: rtl/serial_circular_shifter.sv
// Multi-cycle circular shifter: rotates an N-bit word by a runtime amount,
// one bit position per clock, with valid/ready on both sides and a single
// operation in flight.
// Optional build macro SERIAL_ROT_SHORTEST_PATH_EN: when defined, amounts
// above N/2 are rotated the other way by N - E steps (same result, lower
// worst-case latency).
module serial_circular_shifter
  import serial_rot_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [W-1:0] in_amt,
  input  logic         in_dir,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy
);

  localparam logic [W:0] N_EXT = (W+1)'(N);

  state_t         r_state;
  logic [N-1:0]   r_data;
  logic [W-1:0]   r_cnt;
  logic           r_dir;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_busy;

  logic [W:0]     w_amt_ext;
  logic [W-1:0]   w_eff;
  logic [W-1:0]   w_start_cnt;
  logic           w_start_dir;
  logic [N-1:0]   w_rot;

  // Fold amounts in [N, 2^W) back into [0, N); one subtraction suffices
  // because 2^W < 2N.
  assign w_amt_ext = {1'b0, in_amt};
  assign w_eff     = (w_amt_ext >= N_EXT) ? W'(w_amt_ext - N_EXT) : in_amt;

`ifdef SERIAL_ROT_SHORTEST_PATH_EN
  localparam logic [W:0] HALF_N = (W+1)'(N / 2);
  logic w_go_short;

  // Rotating the other way by N - E gives the same word in fewer steps.
  assign w_go_short  = ({1'b0, w_eff} > HALF_N);
  assign w_start_dir = w_go_short ? ~in_dir : in_dir;
  assign w_start_cnt = w_go_short ? W'(N_EXT - {1'b0, w_eff}) : w_eff;
`else
  assign w_start_dir = in_dir;
  assign w_start_cnt = w_eff;
`endif

  rot1_step #(
    .N (N)
  ) u_rot1_step (
    .data     (r_data),
    .dir      (r_dir),
    .rot_data (w_rot)
  );

  // Control FSM, step counter, data register and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_data      <= '0;
      r_cnt       <= '0;
      r_dir       <= DIR_LEFT;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone means accept.
          if (in_valid) begin
            r_data     <= in_data;
            r_dir      <= w_start_dir;
            r_cnt      <= w_start_cnt;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_start_cnt != '0) begin
              r_state <= SHIFT;
            end else begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          r_data <= w_rot;
          r_cnt  <= r_cnt - W'(1);
          if (r_cnt == W'(1)) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          // Result and state hold for as long as the consumer stalls.
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_serial_circular_shifter.sv
// Self-checking bench for serial_circular_shifter (N = 8): directed cases,
// a timestamp-based transaction model checked every cycle, and random traffic.
module tb_serial_circular_shifter;

  localparam int N = 8;
  localparam int W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic [W-1:0] in_amt = '0;
  logic         in_dir = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_data;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  serial_circular_shifter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rotate: window into a doubled word.
  function automatic logic [N-1:0] rot_ref(input logic [N-1:0] d, input int a, input logic dir);
    logic [2*N-1:0] x;
    int e;
    e = a % N;
    x = {d, d};
    if (dir == 1'b0) begin
      x = x << e;
      return x[2*N-1:N];
    end else begin
      x = x >> e;
      return x[N-1:0];
    end
  endfunction

  // Number of single-bit steps the operation takes.
  function automatic int steps_ref(input int a);
    int e;
    e = a % N;
`ifdef SERIAL_ROT_SHORTEST_PATH_EN
    if (e > N / 2) e = N - e;
`endif
    return e;
  endfunction

  // Transaction model: accept timestamp + step count decide when the
  // result becomes visible; transfer clears the in-flight flag.
  int           cyc = 0;
  int           m_acc = 0;
  int           m_steps = 0;
  bit           m_busy = 1'b0;
  logic [N-1:0] m_result = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (m_busy) begin
        if (cyc >= m_acc + m_steps && out_ready) m_busy <= 1'b0;
      end else if (in_valid) begin
        m_busy   <= 1'b1;
        m_acc    <= cyc + 1;
        m_steps  <= steps_ref(int'(in_amt));
        m_result <= rot_ref(in_data, int'(in_amt), in_dir);
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    bit exp_v;
    if (chk_en && !rst) begin
      exp_v = m_busy && (cyc >= m_acc + m_steps);
      chk(in_ready == !m_busy, "model_in_ready", int'(in_ready), int'(!m_busy));
      chk(busy == m_busy, "model_busy", int'(busy), int'(m_busy));
      chk(out_valid == exp_v, "model_out_valid", int'(out_valid), int'(exp_v));
      if (exp_v && out_valid)
        chk(out_data == m_result, "model_out_data", int'(out_data), int'(m_result));
    end
  end

  // Directed single operation with literal expected data and latency.
  task automatic do_op(input logic [N-1:0] d, input logic [W-1:0] a, input logic dir,
                       input logic [N-1:0] exp_d, input int exp_lat, input int hold,
                       input string name);
    int guard;
    int lat;
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = a;
    in_dir    = dir;
    out_ready = (hold == 0);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk(guard < 50, {name, "_accept_timeout"}, guard, 0);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk(in_ready == 1'b0, {name, "_in_ready_busy"}, int'(in_ready), 0);
      @(negedge clk);
      lat++;
    end
    chk(out_valid == 1'b1, {name, "_valid"}, int'(out_valid), 1);
    chk(lat == exp_lat, {name, "_latency"}, lat, exp_lat);
    chk(out_data == exp_d, {name, "_data"}, int'(out_data), int'(exp_d));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk(out_valid == 1'b1, {name, "_hold_valid"}, int'(out_valid), 1);
      chk(out_data == exp_d, {name, "_hold_data"}, int'(out_data), int'(exp_d));
      chk(in_ready == 1'b0, {name, "_hold_in_ready"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk(in_ready == 1'b1 && out_valid == 1'b0, {name, "_back_idle"},
        int'({in_ready, out_valid}), 2);
  endtask

  initial begin
    int g;
    int t1;
    int t2;

    // Literal pins of the reference model.
    chk(rot_ref(8'b10110101, 3, 1'b0) == 8'b10101101, "pin_rotl3", int'(rot_ref(8'b10110101, 3, 1'b0)), 8'hAD);
    chk(rot_ref(8'b10110101, 3, 1'b1) == 8'b10110110, "pin_rotr3", int'(rot_ref(8'b10110101, 3, 1'b1)), 8'hB6);
    chk(rot_ref(8'b00000001, 7, 1'b0) == 8'b10000000, "pin_rotl7", int'(rot_ref(8'b00000001, 7, 1'b0)), 8'h80);

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk(in_ready == 1'b1, "reset_in_ready", int'(in_ready), 1);
    chk(out_valid == 1'b0, "reset_out_valid", int'(out_valid), 0);
    chk(busy == 1'b0, "reset_busy", int'(busy), 0);
    chk(out_data == '0, "reset_out_data", int'(out_data), 0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    do_op(8'b10110101, 3'd3, 1'b0, 8'b10101101, 4, 0, "rotl3");
    do_op(8'b10110101, 3'd3, 1'b1, 8'b10110110, 4, 0, "rotr3");
    do_op(8'b01100110, 3'd0, 1'b0, 8'b01100110, 1, 0, "amt0");
`ifdef SERIAL_ROT_SHORTEST_PATH_EN
    do_op(8'b00000001, 3'd7, 1'b0, 8'b10000000, 2, 0, "rotl7");
`else
    do_op(8'b00000001, 3'd7, 1'b0, 8'b10000000, 8, 0, "rotl7");
`endif
    do_op(8'b11010001, 3'd3, 1'b1, 8'b00111010, 4, 5, "backpressure");

    // Reset in the middle of a shift.
    in_valid = 1'b1; in_data = 8'hA5; in_amt = 3'd5; in_dir = 1'b0; out_ready = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk(in_ready == 1'b1, "midrst_in_ready", int'(in_ready), 1);
    chk(busy == 1'b0, "midrst_busy", int'(busy), 0);
    chk(out_valid == 1'b0, "midrst_out_valid", int'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    do_op(8'b00100110, 3'd3, 1'b0, 8'b00110001, 4, 0, "after_rst");

    // Back-to-back with in_valid held high.
    in_valid = 1'b1; in_data = 8'hC3; in_amt = 3'd2; in_dir = 1'b0; out_ready = 1'b1;
    g = 0;
    while (!out_valid && g < 50) begin @(negedge clk); g++; end
    t1 = cyc;
    chk(out_data == 8'h0F, "b2b_first_data", int'(out_data), 8'h0F);
    in_data = 8'h5A; in_amt = 3'd1; in_dir = 1'b1;
    @(negedge clk);
    g = 0;
    while (!out_valid && g < 50) begin @(negedge clk); g++; end
    t2 = cyc;
    in_valid = 1'b0;
    chk(out_data == 8'h2D, "b2b_second_data", int'(out_data), 8'h2D);
    chk(t2 - t1 == 3, "b2b_spacing", t2 - t1, 3);
    @(negedge clk);

    // Random traffic with random backpressure and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid  = ($urandom % 3) != 0;
      in_data   = N'($urandom);
      in_amt    = W'($urandom);
      in_dir    = 1'($urandom);
      out_ready = ($urandom % 4) != 0;
      if ($urandom % 500 == 0) begin
        rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk(busy == 1'b0, "drain_idle", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
